// File: rtl/csel_sub_and_unit.sv
// Registered ALU slice: carry-select ADD, two's-complement SUB with borrow, and bitwise AND.
// One request per clock; result and flags appear one cycle after valid_in is sampled.
module csel_sub_and_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             valid_in,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             borrow,
   output logic             overflow,
   output logic             valid_out
);

   localparam int unsigned NBLK = WIDTH / BLOCK;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   if ((WIDTH % BLOCK) != 0 || WIDTH < 2 * BLOCK) begin : g_bad_param
      $error("csel_sub_and_unit: WIDTH must be a multiple of BLOCK and at least 2*BLOCK");
   end

   // Returns {carry_out, sum} of a BLOCK-bit ripple-carry add.
   function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                             input logic [BLOCK-1:0] y,
                                             input logic             c);
      logic [BLOCK-1:0] s;
      logic             cy;
      s  = '0;
      cy = c;
      for (int i = 0; i < int'(BLOCK); i++) begin
         s[i] = x[i] ^ y[i] ^ cy;
         cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
      end
      return {cy, s};
   endfunction

   logic             w_is_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c_in;
   logic [WIDTH-1:0] w_sum;
   logic             w_sum_cout;
   logic             w_sum_ovf;

   // SUB reuses the adder as a + ~b + 1; cin only matters for ADD.
   assign w_is_sub = (op == OP_SUB);
   assign w_b_eff  = w_is_sub ? ~b : b;
   assign w_c_in   = w_is_sub ? 1'b1 : cin;

   // Block 0 ripples from the carry-in; higher blocks precompute both carry cases
   // and the running carry picks one.
   always_comb begin
      logic [BLOCK-1:0] w_a_blk;
      logic [BLOCK-1:0] w_b_blk;
      logic [BLOCK:0]   w_r0;
      logic [BLOCK:0]   w_r1;
      logic [BLOCK:0]   w_sel;
      logic             w_c;
      w_sum   = '0;
      w_a_blk = '0;
      w_b_blk = '0;
      w_r0    = '0;
      w_r1    = '0;
      w_sel   = '0;
      w_c     = w_c_in;
      for (int k = 0; k < int'(NBLK); k++) begin
         w_a_blk = a[k*BLOCK +: BLOCK];
         w_b_blk = w_b_eff[k*BLOCK +: BLOCK];
         if (k == 0) begin
            w_r0 = ripple(w_a_blk, w_b_blk, w_c);
            w_r1 = w_r0;
         end else begin
            w_r0 = ripple(w_a_blk, w_b_blk, 1'b0);
            w_r1 = ripple(w_a_blk, w_b_blk, 1'b1);
         end
         w_sel                     = w_c ? w_r1 : w_r0;
         w_sum[k*BLOCK +: BLOCK]   = w_sel[BLOCK-1:0];
         w_c                       = w_sel[BLOCK];
      end
      w_sum_cout = w_c;
   end

   // With b already inverted for SUB, one formula covers both signed-overflow rules.
   assign w_sum_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

   logic [WIDTH-1:0] w_result;
   logic             w_cout;
   logic             w_borrow;
   logic             w_overflow;

   always_comb begin
      w_result   = '0;
      w_cout     = 1'b0;
      w_borrow   = 1'b0;
      w_overflow = 1'b0;
      unique case (op)
         OP_ADD: begin
            w_result   = w_sum;
            w_cout     = w_sum_cout;
            w_overflow = w_sum_ovf;
         end
         OP_SUB: begin
            w_result   = w_sum;
            w_borrow   = ~w_sum_cout;
            w_overflow = w_sum_ovf;
         end
         OP_AND: begin
            w_result = a & b;
         end
         OP_RSV: begin
            w_result = '0;
         end
      endcase
   end

   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_borrow;
   logic             r_overflow;
   logic             r_valid;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_result   <= '0;
         r_cout     <= 1'b0;
         r_borrow   <= 1'b0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= valid_in;
         if (valid_in) begin
            r_result   <= w_result;
            r_cout     <= w_cout;
            r_borrow   <= w_borrow;
            r_overflow <= w_overflow;
         end
      end
   end

   assign result    = r_result;
   assign cout      = r_cout;
   assign borrow    = r_borrow;
   assign overflow  = r_overflow;
   assign valid_out = r_valid;

endmodule

// File: tb/tb_csel_sub_and_unit.sv
// Directed-vector and reference-model bench for csel_sub_and_unit at WIDTH 32 and 16.
module tb_csel_sub_and_unit;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] AND = 2'b10;
   localparam logic [1:0] RSV = 2'b11;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        valid_in;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;

   logic [31:0] result;
   logic        cout, borrow, overflow, valid_out;
   logic [15:0] result16;
   logic        cout16, borrow16, overflow16, valid_out16;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   csel_sub_and_unit #(.WIDTH(32), .BLOCK(4)) u_dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .valid_in  (valid_in),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .result    (result),
      .cout      (cout),
      .borrow    (borrow),
      .overflow  (overflow),
      .valid_out (valid_out)
   );

   csel_sub_and_unit #(.WIDTH(16), .BLOCK(4)) u_dut16 (
      .clk       (clk),
      .rst_b     (rst_b),
      .valid_in  (valid_in),
      .op        (op),
      .a         (a[15:0]),
      .b         (b[15:0]),
      .cin       (cin),
      .result    (result16),
      .cout      (cout16),
      .borrow    (borrow16),
      .overflow  (overflow16),
      .valid_out (valid_out16)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] res;
      logic [2:0]  flags; // {cout, borrow, overflow}
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   // Packed outputs: {result, cout, borrow, overflow, valid_out}
   function automatic logic [35:0] got32();
      return {result, cout, borrow, overflow, valid_out};
   endfunction

   function automatic logic [35:0] got16();
      return {16'h0, result16, cout16, borrow16, overflow16, valid_out16};
   endfunction

   // Independent behavioural model, returns {result, cout, borrow, overflow}.
   function automatic logic [34:0] ref_model(input int w, input logic [1:0] o,
                                             input logic [31:0] x, input logic [31:0] y,
                                             input logic c);
      longint unsigned mask, xm, ym, s, r;
      logic co, bo, ov;
      int msb;
      mask = (64'd1 << w) - 64'd1;
      xm   = x & mask;
      ym   = y & mask;
      msb  = w - 1;
      co = 1'b0; bo = 1'b0; ov = 1'b0; r = 0;
      case (o)
         ADD: begin
            s  = xm + ym + longint'(c);
            r  = s & mask;
            co = s[w];
            ov = (xm[msb] == ym[msb]) && (r[msb] != xm[msb]);
         end
         SUB: begin
            r  = (xm - ym) & mask;
            bo = xm < ym;
            ov = (xm[msb] != ym[msb]) && (r[msb] != xm[msb]);
         end
         AND: r = xm & ym;
         default: r = 0;
      endcase
      return {r[31:0], co, bo, ov};
   endfunction

   task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got res=%h co=%b bo=%b ov=%b vo=%b, want res=%h co=%b bo=%b ov=%b vo=%b",
                  name, got[35:4], got[3], got[2], got[1], got[0],
                  exp[35:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      logic [34:0] exp32, exp16, prev32, prev16;
      logic        v;

      vecs[0]  = '{ADD, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 3'b000};
      vecs[1]  = '{ADD, 32'hFFFFFF9B, 32'h0000003F, 1'b0, 32'hFFFFFFDA, 3'b000};
      vecs[2]  = '{SUB, 32'hFFFFFF9B, 32'h0000003F, 1'b0, 32'hFFFFFF5C, 3'b000};
      vecs[3]  = '{SUB, 32'h0000003F, 32'hFFFFFF9B, 1'b0, 32'h000000A4, 3'b010};
      vecs[4]  = '{AND, 32'hFFFFFF9B, 32'h0000003F, 1'b1, 32'h0000001B, 3'b000};
      vecs[5]  = '{RSV, 32'hFFFFFF9B, 32'h0000003F, 1'b1, 32'h00000000, 3'b000};
      vecs[6]  = '{ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 3'b001};
      vecs[7]  = '{ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 3'b100};
      vecs[8]  = '{SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 3'b001};
      vecs[9]  = '{SUB, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 3'b000};
      vecs[10] = '{SUB, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 3'b010};
      vecs[11] = '{ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 3'b101};
      vecs[12] = '{ADD, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 3'b000};
      vecs[13] = '{SUB, 32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 3'b000};
      vecs[14] = '{AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 3'b000};

      // Requests presented during reset must be discarded.
      rst_b    = 1'b0;
      valid_in = 1'b1;
      op       = ADD;
      a        = $urandom;
      b        = $urandom;
      cin      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", got32(), 36'h0);
      check("reset_hold16", got16(), 36'h0);

      @(negedge clk);
      rst_b = 1'b1;
      a = 32'h1; b = 32'h1; cin = 1'b0; op = ADD; valid_in = 1'b1;
      @(posedge clk); #1;
      check("add_1_1", got32(), {32'h2, 4'b0001});

      @(negedge clk);
      valid_in = 1'b0;
      a = $urandom; b = $urandom; op = SUB;
      @(posedge clk); #1;
      check("single_pulse_hold", got32(), {32'h2, 4'b0000});

      // Back-to-back table; the last three entries are ADD, SUB, AND.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
         valid_in = 1'b1;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), got32(), {vecs[i].res, vecs[i].flags, 1'b1});
      end

      @(negedge clk);
      valid_in = 1'b0;
      a = 32'hDEADBEEF; b = 32'h12345678; op = ADD;
      @(posedge clk); #1;
      check("stream_idle_hold", got32(), {32'h00F000F0, 4'b0000});

      // Asynchronous reset between clock edges.
      @(negedge clk);
      op = ADD; a = 32'h5; b = 32'h6; cin = 1'b0; valid_in = 1'b1;
      @(posedge clk); #1;
      check("pre_reset_add", got32(), {32'hB, 4'b0001});
      #2 rst_b = 1'b0;
      #1;
      check("async_reset", got32(), 36'h0);
      check("async_reset16", got16(), 36'h0);
      @(posedge clk); #1;
      check("reset_discard", got32(), 36'h0);
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk); #1;
      check("post_reset_add", got32(), {32'hB, 4'b0001});
      check("post_reset_add16", got16(), {16'h0, 16'hB, 4'b0001});

      prev32 = {32'hB, 3'b000};
      prev16 = {32'hB, 3'b000};
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         v        = ($urandom_range(3) != 0);
         valid_in = v;
         op       = 2'($urandom_range(3));
         a        = $urandom;
         b        = $urandom;
         cin      = 1'($urandom_range(1));
         if (i % 8 == 0) b = a;
         exp32 = v ? ref_model(32, op, a, b, cin) : prev32;
         exp16 = v ? ref_model(16, op, a, b, cin) : prev16;
         @(posedge clk); #1;
         check($sformatf("rand32_%0d", i), got32(), {exp32, v});
         check($sformatf("rand16_%0d", i), got16(), {exp16, v});
         prev32 = exp32;
         prev16 = exp16;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
